// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse transmit/receive path.
//   - Symbol pair codes (2 bits per symbol, right-aligned patterns,
//     lowest nonzero pair = last symbol).
//   - Highest valid letter number (1..26 = A..Z, 27..35 = 1..9, 36 = 0).
//   - Transmit FSM state encoding.
//   - morse_pattern(): the letter -> pattern table. The decoder uses the same
//     table, so any change here changes both directions.
//   - morse_len() / morse_left_align(): helpers for loading the shift register.
// -----------------------------------------------------------------------------
package morse_pkg;

    localparam logic [1:0] SYM_NONE   = 2'b00;
    localparam logic [1:0] SYM_DOT    = 2'b01;
    localparam logic [1:0] SYM_DASH   = 2'b11;
    localparam logic [5:0] LETTER_MAX = 6'd36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SGAP,
        ST_LGAP,
        ST_DONE
    } morse_state_e;

    // Right-aligned symbol pattern for a letter number; 0 for word space and
    // for out-of-range codes.
    function automatic logic [9:0] morse_pattern(input logic [5:0] letter_num);
        logic [9:0] p;
        case (letter_num)
            6'd1:    p = 10'b00_00_00_01_11; // A .-
            6'd2:    p = 10'b00_11_01_01_01; // B -...
            6'd3:    p = 10'b00_11_01_11_01; // C -.-.
            6'd4:    p = 10'b00_00_11_01_01; // D -..
            6'd5:    p = 10'b00_00_00_00_01; // E .
            6'd6:    p = 10'b00_01_01_11_01; // F ..-.
            6'd7:    p = 10'b00_00_11_11_01; // G --.
            6'd8:    p = 10'b00_01_01_01_01; // H ....
            6'd9:    p = 10'b00_00_00_01_01; // I ..
            6'd10:   p = 10'b00_01_11_11_11; // J .---
            6'd11:   p = 10'b00_00_11_01_11; // K -.-
            6'd12:   p = 10'b00_01_11_01_01; // L .-..
            6'd13:   p = 10'b00_00_00_11_11; // M --
            6'd14:   p = 10'b00_00_00_11_01; // N -.
            6'd15:   p = 10'b00_00_11_11_11; // O ---
            6'd16:   p = 10'b00_01_11_11_01; // P .--.
            6'd17:   p = 10'b00_11_11_01_11; // Q --.-
            6'd18:   p = 10'b00_00_01_11_01; // R .-.
            6'd19:   p = 10'b00_00_01_01_01; // S ...
            6'd20:   p = 10'b00_00_00_00_11; // T -
            6'd21:   p = 10'b00_00_01_01_11; // U ..-
            6'd22:   p = 10'b00_01_01_01_11; // V ...-
            6'd23:   p = 10'b00_00_01_11_11; // W .--
            6'd24:   p = 10'b00_11_01_01_11; // X -..-
            6'd25:   p = 10'b00_11_01_11_11; // Y -.--
            6'd26:   p = 10'b00_11_11_01_01; // Z --..
            6'd27:   p = 10'b01_11_11_11_11; // 1 .----
            6'd28:   p = 10'b01_01_11_11_11; // 2 ..---
            6'd29:   p = 10'b01_01_01_11_11; // 3 ...--
            6'd30:   p = 10'b01_01_01_01_11; // 4 ....-
            6'd31:   p = 10'b01_01_01_01_01; // 5 .....
            6'd32:   p = 10'b11_01_01_01_01; // 6 -....
            6'd33:   p = 10'b11_11_01_01_01; // 7 --...
            6'd34:   p = 10'b11_11_11_01_01; // 8 ---..
            6'd35:   p = 10'b11_11_11_11_01; // 9 ----.
            6'd36:   p = 10'b11_11_11_11_11; // 0 -----
            default: p = 10'b00_00_00_00_00; // word space / invalid
        endcase
        return p;
    endfunction

    // Symbol count = index of highest nonzero pair + 1.
    function automatic logic [2:0] morse_len(input logic [9:0] pattern);
        logic [2:0] n;
        if      (pattern[9:8] != SYM_NONE) n = 3'd5;
        else if (pattern[7:6] != SYM_NONE) n = 3'd4;
        else if (pattern[5:4] != SYM_NONE) n = 3'd3;
        else if (pattern[3:2] != SYM_NONE) n = 3'd2;
        else if (pattern[1:0] != SYM_NONE) n = 3'd1;
        else                               n = 3'd0;
        return n;
    endfunction

    // Moves the first symbol of a right-aligned pattern into bits [9:8].
    function automatic logic [9:0] morse_left_align(input logic [9:0] pattern,
                                                    input logic [2:0] len);
        logic [9:0] a;
        case (len)
            3'd5:    a = pattern;
            3'd4:    a = {pattern[7:0], 2'b00};
            3'd3:    a = {pattern[5:0], 4'b0000};
            3'd2:    a = {pattern[3:0], 6'b00_0000};
            3'd1:    a = {pattern[1:0], 8'b0000_0000};
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Down-counter used for every Morse interval. Loading (duration-1) makes
// zero_o read 1 on the last cycle of the interval, so the owner advances on
// that cycle with no extra idle cycle between intervals.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset (counter -> 0)
//   load_i      in   load load_val_i this edge (has priority over en_i)
//   load_val_i  in   W-bit value to load
//   en_i        in   count down by one when nonzero
//   zero_o      out  counter currently reads zero
// -----------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/morse_encoder_tx.sv
// -----------------------------------------------------------------------------
// morse_encoder_tx
// Keys a letter number out as Morse code with standard unit timing.
// Dot = 1 unit high, dash = 3 units high, 1 unit low between symbols,
// CHAR_GAP_U units low after a letter, WORD_GAP_U units low for a word space
// (letter_num 0). Codes above LETTER_MAX finish at once with err.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, sampled only while ready=1
//   letter_num  in   6-bit letter code, captured on the accepting edge
//   ready       out  idle, able to accept start
//   morse_out   out  keyed output, 1 = tone/LED on
//   done        out  1-cycle pulse when the letter and its trailing gap end
//   err         out  1-cycle pulse with done for letter_num > LETTER_MAX
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module morse_encoder_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 50_000_000 / 10,
    parameter int CHAR_GAP_U  = 3,
    parameter int WORD_GAP_U  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] letter_num,
    output logic       ready,
    output logic       morse_out,
    output logic       done,
    output logic       err
);

    localparam int TIMER_W = $clog2(WORD_GAP_U * UNIT_CYCLES + 1);

    // Timer load values are (duration - 1).
    localparam logic [TIMER_W-1:0] DOT_LD  = TIMER_W'(UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DASH_LD = TIMER_W'(3 * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CGAP_LD = TIMER_W'(CHAR_GAP_U * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WGAP_LD = TIMER_W'(WORD_GAP_U * UNIT_CYCLES - 1);

    function automatic logic [TIMER_W-1:0] sym_load(input logic [1:0] pair);
        logic [TIMER_W-1:0] v;
        case (pair)
            SYM_DASH: v = DASH_LD;
            SYM_DOT:  v = DOT_LD;
            default:  v = DOT_LD;
        endcase
        return v;
    endfunction

    morse_state_e       state_q, state_d;
    logic [9:0]         shift_q, shift_d;
    logic [2:0]         len_q, len_d;
    logic [5:0]         letter_q, letter_d;
    logic               out_q, out_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero;

    logic [9:0]         rom_pat;
    logic [2:0]         rom_len;

    assign rom_pat = morse_pattern(letter_num);
    assign rom_len = morse_len(rom_pat);

    // Count only while an interval is running; IDLE/DONE leave it parked.
    assign tmr_en = (state_q == ST_MARK) || (state_q == ST_SGAP) || (state_q == ST_LGAP);

    morse_unit_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        shift_d  = shift_q;
        len_d    = len_q;
        letter_d = letter_q;
        out_d    = out_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    letter_d = letter_num;
                    ready_d  = 1'b0;
                    if (letter_num > LETTER_MAX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (rom_len == 3'd0) begin
                        // Word space: nothing to key, just the long gap.
                        state_d  = ST_LGAP;
                        tmr_load = 1'b1;
                        tmr_val  = WGAP_LD;
                    end else begin
                        // First mark starts on the accept edge itself.
                        shift_d  = morse_left_align(rom_pat, rom_len);
                        len_d    = rom_len;
                        state_d  = ST_MARK;
                        out_d    = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = sym_load(shift_d[9:8]);
                    end
                end
            end

            ST_MARK: begin
                if (tmr_zero) begin
                    out_d    = 1'b0;
                    shift_d  = {shift_q[7:0], 2'b00};
                    len_d    = len_q - 3'd1;
                    tmr_load = 1'b1;
                    if (len_q == 3'd1) begin
                        state_d = ST_LGAP;
                        tmr_val = (letter_q == 6'd0) ? WGAP_LD : CGAP_LD;
                    end else begin
                        state_d = ST_SGAP;
                        tmr_val = DOT_LD;
                    end
                end
            end

            ST_SGAP: begin
                if (tmr_zero) begin
                    state_d  = ST_MARK;
                    out_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = sym_load(shift_q[9:8]);
                end
            end

            ST_LGAP: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            len_q    <= '0;
            letter_q <= '0;
            out_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            len_q    <= len_d;
            letter_q <= letter_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ready     = ready_q;
    assign morse_out = out_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morse_encoder_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder_tx
// Directed bench for morse_encoder_tx with UNIT_CYCLES=4, CHAR_GAP_U=3,
// WORD_GAP_U=7. Each letter is keyed, the bench re-packs the observed marks
// into a right-aligned pattern and measures accept-to-done latency and the
// trailing low run against hand-computed or table-derived values.
// -----------------------------------------------------------------------------
module tb_morse_encoder_tx;
    import morse_pkg::*;

    localparam int UNIT     = 4;
    localparam int MAX_WAIT = 200;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] letter_num;
    logic       ready;
    logic       morse_out;
    logic       done;
    logic       err;

    int checks;
    int errors;

    string tbl [0:36];

    morse_encoder_tx #(
        .UNIT_CYCLES (UNIT),
        .CHAR_GAP_U  (3),
        .WORD_GAP_U  (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .letter_num (letter_num),
        .ready      (ready),
        .morse_out  (morse_out),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with ready=1; returns at the negedge after the one
    // where ready is back, so calls chain back-to-back.
    task automatic send(input string tag, input logic [5:0] n, input bit hammer,
                        input logic [9:0] exp_pat, input int exp_cyc,
                        input int exp_tail, input logic exp_err);
        logic [9:0] pat;
        int         hi, lo, marks, done_cyc;
        logic       err_seen, shape_ok, ready_at_done;
        pat = '0; hi = 0; lo = 0; marks = 0; done_cyc = 0;
        err_seen = 1'b0; shape_ok = 1'b1; ready_at_done = 1'b1;

        check({tag, ".ready_in"}, ready, 1);
        start      = 1'b1;
        letter_num = n;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            if (hammer) begin
                start      = 1'b1;
                letter_num = letter_num ^ 6'h21;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc      = k;
                err_seen      = err;
                ready_at_done = ready;
                break;
            end
            if (ready) shape_ok = 1'b0;
            if (morse_out) begin
                if (hi == 0) begin
                    // First mark must begin right after accept; later marks
                    // follow exactly one unit of silence.
                    if ((marks == 0) ? (lo != 0) : (lo != UNIT)) shape_ok = 1'b0;
                    lo = 0;
                end
                hi++;
            end else begin
                if (hi > 0) begin
                    marks++;
                    if (hi == UNIT)          pat = {pat[7:0], SYM_DOT};
                    else if (hi == 3 * UNIT) pat = {pat[7:0], SYM_DASH};
                    else                     shape_ok = 1'b0;
                    hi = 0;
                end
                lo++;
            end
        end
        start = 1'b0;
        if (hi != 0) shape_ok = 1'b0;

        check({tag, ".done_cyc"}, done_cyc, exp_cyc);
        check({tag, ".pattern"}, pat, exp_pat);
        check({tag, ".tail_low"}, lo, exp_tail);
        check({tag, ".err"}, err_seen, exp_err);
        check({tag, ".shape"}, shape_ok, 1);
        check({tag, ".ready_at_done"}, ready_at_done, 0);
        @(negedge clk);
        check({tag, ".ready_after"}, ready, 1);
        check({tag, ".out_after"}, morse_out, 0);
        check({tag, ".done_after"}, done, 0);
        check({tag, ".err_after"}, err, 0);
    endtask

    initial begin
        logic [9:0] m_pat;
        int         m_cyc, m_tail;
        string      s;

        checks = 0;
        errors = 0;
        tbl = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                "---..", "----.", "-----"};

        rst_n      = 1'b0;
        start      = 1'b0;
        letter_num = 6'd0;
        repeat (3) @(negedge clk);
        check("rst.ready", ready, 1);
        check("rst.morse_out", morse_out, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.ready", ready, 1);

        // E: 4 high, 12 low, done at 17
        send("E", 6'd5, 1'b0, 10'h001, 17, 12, 1'b0);
        // Digit 0: five dashes, 89 cycles accept-to-done... ready one later
        send("D0", 6'd36, 1'b0, 10'h3FF, 89, 12, 1'b0);
        // Word space: 28 low, never high
        send("WS", 6'd0, 1'b0, 10'h000, 29, 28, 1'b0);
        // Invalid code: done+err right after accept
        send("ERR40", 6'd40, 1'b0, 10'h000, 1, 0, 1'b1);
        // B with start held and letter_num toggling throughout
        send("B_hammer", 6'd2, 1'b1, 10'h0D5, 49, 12, 1'b0);

        // Reset in the middle of K's first dash
        start      = 1'b1;
        letter_num = 6'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("K_abort.mid_dash", morse_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("K_abort.out", morse_out, 0);
        check("K_abort.ready", ready, 1);
        check("K_abort.done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("K_abort.no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send("K_fresh", 6'd11, 1'b0, 10'h037, 49, 12, 1'b0);

        // Loopback over every valid code, back-to-back
        for (int n = 0; n <= 36; n++) begin
            s      = tbl[n];
            m_pat  = '0;
            m_cyc  = 0;
            for (int i = 0; i < s.len(); i++) begin
                if (s[i] == "-") begin
                    m_pat = {m_pat[7:0], 2'b11};
                    m_cyc += 3 * UNIT;
                end else begin
                    m_pat = {m_pat[7:0], 2'b01};
                    m_cyc += UNIT;
                end
                if (i > 0) m_cyc += UNIT;
            end
            m_tail = (s.len() == 0) ? 7 * UNIT : 3 * UNIT;
            m_cyc  = m_cyc + m_tail + 1;
            check($sformatf("rom[%0d]", n), morse_pattern(6'(n)), m_pat);
            send($sformatf("loop[%0d]", n), 6'(n), 1'b0, m_pat, m_cyc, m_tail, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
